// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_pkg
// Description : Shared constants, button indices and arbiter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

  localparam int N_BTN = 5;
  localparam int ID_W  = 3;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_repeat_timer.sv
`default_nettype none
// ============================================================================
// Module      : btn_repeat_timer
// Description : Hold counter producing one-cycle auto-repeat ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat_timer #(
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic enable,
  input  logic level,
  output logic repeat_tick
);
  import btn_evt_pkg::*;

  localparam int c_cnt_w = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(REPEAT_PERIOD - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_repeating;
  logic               r_tick;
  logic               w_hit;

  // Counter restarts at zero after each tick, so it never exceeds the larger limit.
  assign w_hit = (r_cnt == (r_repeating ? c_period_last : c_delay_last));

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_repeating <= 1'b0;
      r_tick      <= 1'b0;
    end else if (!(enable && level)) begin
      r_cnt       <= '0;
      r_repeating <= 1'b0;
      r_tick      <= 1'b0;
    end else if (w_hit) begin
      r_cnt       <= '0;
      r_repeating <= 1'b1;
      r_tick      <= 1'b1;
    end else begin
      r_cnt       <= r_cnt + 1'b1;
      r_tick      <= 1'b0;
    end
  end

  assign repeat_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Round-robin arbiter turning button presses/auto-repeats into events.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
  parameter int               N_BTN         = btn_evt_pkg::N_BTN,
  parameter int               REPEAT_DELAY  = 50000000,
  parameter int               REPEAT_PERIOD = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(5'b00011)
) (
  input  logic                         clk_100mhz,
  input  logic                         rst_n,
  input  logic [N_BTN-1:0]             btn_pulse,
  input  logic [N_BTN-1:0]             btn_level,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [btn_evt_pkg::ID_W-1:0] evt_id,
  output logic                         evt_repeat,
  output logic [7:0]                   drop_cnt
);
  import btn_evt_pkg::*;

  arb_state_t       r_state, w_state_nxt;
  logic             r_evt_valid, w_evt_valid_nxt;
  logic [ID_W-1:0]  r_evt_id, w_evt_id_nxt;
  logic             r_evt_repeat, w_evt_repeat_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]  w_grant, w_cand;
  logic             w_found;
  logic             w_accept_any;

  logic [N_BTN-1:0] r_pending, w_pending_nxt;
  logic [N_BTN-1:0] r_is_repeat, w_is_repeat_nxt;
  logic [N_BTN-1:0] w_tick, w_accept, w_drop;
  logic [7:0]       r_drop_cnt, w_drop_cnt_nxt;
  logic [8:0]       w_drop_sum;

  assign w_accept_any = (r_state == OFFER) && evt_ready;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_repeat_timer #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_timer (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .enable      (REPEAT_MASK[i]),
        .level       (btn_level[i]),
        .repeat_tick (w_tick[i])
      );
      assign w_accept[i] = w_accept_any && (r_evt_id == ID_W'(i));
    end
  endgenerate

  // A press on a pending repeat upgrades it; only genuinely lost requests count as drops.
  always_comb begin
    w_pending_nxt   = r_pending;
    w_is_repeat_nxt = r_is_repeat;
    w_drop          = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_pulse[i] || w_tick[i]) begin
        w_drop[i]        = r_pending[i] && !w_accept[i] && !(btn_pulse[i] && r_is_repeat[i]);
        w_pending_nxt[i] = 1'b1;
        if (btn_pulse[i]) begin
          w_is_repeat_nxt[i] = 1'b0;
        end else if (!r_pending[i] || w_accept[i]) begin
          w_is_repeat_nxt[i] = 1'b1;
        end
      end else if (w_accept[i]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_drop_sum = {1'b0, r_drop_cnt};
    for (int i = 0; i < N_BTN; i++) begin
      w_drop_sum = w_drop_sum + 9'(w_drop[i]);
    end
    w_drop_cnt_nxt = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_is_repeat <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_is_repeat <= w_is_repeat_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_evt_repeat <= 1'b0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_evt_valid  <= w_evt_valid_nxt;
      r_evt_id     <= w_evt_id_nxt;
      r_evt_repeat <= w_evt_repeat_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_evt_valid_nxt  = r_evt_valid;
    w_evt_id_nxt     = r_evt_id;
    w_evt_repeat_nxt = r_evt_repeat;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_found          = 1'b0;
    w_grant          = '0;
    w_cand           = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % N_BTN);
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt      = OFFER;
          w_evt_valid_nxt  = 1'b1;
          w_evt_id_nxt     = w_grant;
          w_evt_repeat_nxt = r_is_repeat[w_grant];
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_state_nxt     = IDLE;
          w_evt_valid_nxt = 1'b0;
          w_rr_ptr_nxt    = (r_evt_id == ID_W'(N_BTN - 1)) ? '0 : r_evt_id + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_evt_valid_nxt = 1'b0;
      end
    endcase
  end

  assign evt_valid  = r_evt_valid;
  assign evt_id     = r_evt_id;
  assign evt_repeat = r_evt_repeat;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
